// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score board and its renderer.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAX_DIGITS  = 6;
    localparam int SCORE_W_MAX = 4 * MAX_DIGITS;

    // Compare two BCD numbers most significant digit first; true when a > b.
    function automatic logic bcd_gt(input logic [SCORE_W_MAX-1:0] a,
                                    input logic [SCORE_W_MAX-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

    // Start address of a glyph in a ROM that stores glyphs 0..9 back to back.
    function automatic int glyph_offset(input bcd_digit_t digit, input int w, input int h);
        return int'(digit) * w * h;
    endfunction

endpackage

// File: rtl/bcd_addsub.sv
// Multi-digit BCD ripple adder/subtractor applying a single-digit delta to digit 0.
module bcd_addsub
    import score_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] value,
    input  bcd_digit_t          amount,
    input  logic                sub,
    output logic [4*DIGITS-1:0] result,
    output logic                carry_out,
    output logic                borrow_out
);

    logic [4:0] acc;
    logic [4:0] need;
    logic       chain;
    bcd_digit_t operand;

    // Ripple digit by digit, carrying on add or borrowing on subtract.
    always_comb begin
        result  = '0;
        acc     = '0;
        need    = '0;
        chain   = 1'b0;
        operand = '0;
        for (int i = 0; i < DIGITS; i++) begin
            operand = (i == 0) ? amount : 4'd0;
            if (!sub) begin
                acc = {1'b0, value[4*i +: 4]} + {1'b0, operand} + {4'd0, chain};
                if (acc > 5'd9) begin
                    acc   = acc - 5'd10;
                    chain = 1'b1;
                end else begin
                    chain = 1'b0;
                end
            end else begin
                need = {1'b0, operand} + {4'd0, chain};
                if ({1'b0, value[4*i +: 4]} < need) begin
                    acc   = {1'b0, value[4*i +: 4]} + 5'd10 - need;
                    chain = 1'b1;
                end else begin
                    acc   = {1'b0, value[4*i +: 4]} - need;
                    chain = 1'b0;
                end
            end
            result[4*i +: 4] = acc[3:0];
        end
        carry_out  = ~sub & chain;
        borrow_out = sub & chain;
    end

endmodule

// File: rtl/score_board_bcd.sv
// N-digit BCD score counter with high score tracking and a glyph overlay renderer.
module score_board_bcd
    import score_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int GLYPH_W  = 60,
    parameter int GLYPH_H  = 80,
    parameter int ORIGIN_X = 560,
    parameter int ORIGIN_Y = 0,
    parameter int H_LAST   = 799,
    parameter int V_LAST   = 599,
    parameter int ADDR_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                add,
    input  logic                decr,
    input  logic [3:0]          amount,
    input  logic                clear,
    input  logic [11:0]         x_p,
    input  logic [11:0]         y_p,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic                rom_dout,
    output logic                isFilled,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [4*DIGITS-1:0] high_bcd,
    output logic                new_high,
    output logic                saturated,
    output logic                gameover
);

    localparam int SCORE_W = 4 * DIGITS;
    localparam logic [SCORE_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [11:0] H_LAST_C = 12'(H_LAST);
    localparam logic [11:0] V_LAST_C = 12'(V_LAST);
    localparam logic [11:0] X_LO     = 12'(ORIGIN_X);
    localparam logic [11:0] X_HI     = 12'(ORIGIN_X + DIGITS * GLYPH_W);
    localparam logic [11:0] Y_LO     = 12'(ORIGIN_Y);
    localparam logic [11:0] Y_HI     = 12'(ORIGIN_Y + GLYPH_H);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("score_board_bcd: DIGITS out of range");
    end
    if (10 * GLYPH_W * GLYPH_H > (1 << ADDR_W)) begin : g_bad_addr
        $error("score_board_bcd: glyph ROM does not fit in ADDR_W bits");
    end

    bcd_digit_t             amount_eff;
    logic [SCORE_W-1:0]     next_val;
    logic                   carry_out;
    logic                   borrow_out;
    logic [SCORE_W_MAX-1:0] score_ext;
    logic [SCORE_W_MAX-1:0] high_ext;

    assign amount_eff = ((amount == 4'd0) || (amount > 4'd9)) ? 4'd1 : amount;

    bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
        .value      (score_bcd),
        .amount     (amount_eff),
        .sub        (decr),
        .result     (next_val),
        .carry_out  (carry_out),
        .borrow_out (borrow_out)
    );

    // Score update with priority clear > gameover hold > decr > add.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_bcd <= '0;
            gameover  <= 1'b0;
            saturated <= 1'b0;
        end else if (clear) begin
            score_bcd <= '0;
            gameover  <= 1'b0;
            saturated <= 1'b0;
        end else if (gameover) begin
            score_bcd <= '0;
        end else if (decr) begin
            if (borrow_out || (next_val == '0)) begin
                score_bcd <= '0;
                gameover  <= 1'b1;
            end else begin
                score_bcd <= next_val;
            end
        end else if (add) begin
            if (carry_out) begin
                score_bcd <= ALL_NINES;
                saturated <= 1'b1;
            end else begin
                score_bcd <= next_val;
            end
        end
    end

    // Widen both values so the shared compare helper works for any digit count.
    always_comb begin
        score_ext                = '0;
        high_ext                 = '0;
        score_ext[SCORE_W-1:0]   = score_bcd;
        high_ext[SCORE_W-1:0]    = high_bcd;
    end

    // Track the session high score one edge behind the score, pulsing new_high on updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_bcd <= '0;
            new_high <= 1'b0;
        end else begin
            new_high <= 1'b0;
            if (bcd_gt(score_ext, high_ext)) begin
                high_bcd <= score_bcd;
                new_high <= 1'b1;
            end
        end
    end

    logic [11:0]       lx;
    logic [11:0]       ly;
    logic [11:0]       rel_x;
    logic [11:0]       rel_y;
    logic [11:0]       slot_x0;
    logic              in_region;
    logic              leading;
    logic [DIGITS-1:0] blank_vec;
    logic              blank_la;
    bcd_digit_t        digit_val;
    logic              in_region_q;
    logic              blank_q;

    // Lookahead to the next pixel so the ROM latency lines up with the current one.
    always_comb begin
        lx = x_p + 12'd1;
        ly = y_p;
        if (x_p == H_LAST_C) begin
            lx = '0;
            ly = (y_p == V_LAST_C) ? 12'd0 : y_p + 12'd1;
        end
    end

    assign in_region = (lx >= X_LO) && (lx < X_HI) && (ly >= Y_LO) && (ly < Y_HI);
    assign rel_x     = lx - X_LO;
    assign rel_y     = ly - Y_LO;

    // Leading-zero blanking: a digit is blank while it and every digit above it are zero.
    always_comb begin
        leading   = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            leading      = leading & (score_bcd[4*i +: 4] == 4'd0);
            blank_vec[i] = (i != 0) && leading;
        end
    end

    // Pick the slot under the lookahead pixel; slot k shows digit DIGITS-1-k.
    always_comb begin
        slot_x0   = '0;
        digit_val = '0;
        blank_la  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (rel_x >= 12'(k * GLYPH_W)) begin
                slot_x0   = 12'(k * GLYPH_W);
                digit_val = score_bcd[4*(DIGITS-1-k) +: 4];
                blank_la  = blank_vec[DIGITS-1-k];
            end
        end
    end

    // Glyph ROM address for the lookahead pixel, zero outside the digit row.
    always_comb begin
        rom_addr = '0;
        if (in_region) begin
            rom_addr = ADDR_W'(glyph_offset(digit_val, GLYPH_W, GLYPH_H))
                     + ADDR_W'(rel_y) * ADDR_W'(GLYPH_W)
                     + ADDR_W'(rel_x - slot_x0);
        end
    end

    // Carry region and blanking alongside the ROM access so they meet its data.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_region_q <= 1'b0;
            blank_q     <= 1'b0;
        end else begin
            in_region_q <= in_region;
            blank_q     <= blank_la;
        end
    end

    assign isFilled = in_region_q & ~blank_q & rom_dout;

endmodule

// File: tb/tb_score_board_bcd.sv
// Directed self-checking bench for score_board_bcd with hand-computed expectations.
module tb_score_board_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        add;
    logic        decr;
    logic [3:0]  amount;
    logic        clear;
    logic [11:0] x_p;
    logic [11:0] y_p;
    logic [15:0] rom_addr;
    logic        rom_dout;
    logic        isFilled;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic        new_high;
    logic        saturated;
    logic        gameover;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    score_board_bcd dut (
        .clk       (clk),
        .reset     (reset),
        .add       (add),
        .decr      (decr),
        .amount    (amount),
        .clear     (clear),
        .x_p       (x_p),
        .y_p       (y_p),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .isFilled  (isFilled),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .new_high  (new_high),
        .saturated (saturated),
        .gameover  (gameover)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic d, input logic c, input logic [3:0] amt);
        add    = a;
        decr   = d;
        clear  = c;
        amount = amt;
        tick();
        add    = 1'b0;
        decr   = 1'b0;
        clear  = 1'b0;
        amount = 4'd1;
    endtask

    task automatic addMany(input int n, input logic [3:0] amt);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, amt);
    endtask

    // Check the address for (x,y), then present rom_dout=1 one cycle later and check isFilled.
    task automatic probe(input logic [11:0] x, input logic [11:0] y,
                         input logic [15:0] exp_addr, input logic exp_fill, input string tag);
        x_p      = x;
        y_p      = y;
        rom_dout = 1'b0;
        #1;
        checkOutput({tag, "_addr"}, rom_addr, exp_addr);
        tick();
        rom_dout = 1'b1;
        #1;
        checkOutput({tag, "_fill"}, isFilled, exp_fill);
        rom_dout = 1'b0;
    endtask

    initial begin
        reset = 1'b1; add = 1'b0; decr = 1'b0; clear = 1'b0; amount = 4'd1;
        x_p = '0; y_p = '0; rom_dout = 1'b0;
        tick();
        tick();
        checkOutput("rst_score", score_bcd, 16'h0000);
        checkOutput("rst_high", high_bcd, 16'h0000);
        checkOutput("rst_gameover", gameover, 1'b0);
        checkOutput("rst_saturated", saturated, 1'b0);
        checkOutput("rst_new_high", new_high, 1'b0);
        reset = 1'b0;
        rom_dout = 1'b1;
        #1;
        checkOutput("rst_fill", isFilled, 1'b0);
        rom_dout = 1'b0;

        $display("[TB] twelve single-point adds");
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd1);
            if (new_high) pulses++;
        end
        tick();
        if (new_high) pulses++;
        checkOutput("add12_score", score_bcd, 16'h0012);
        checkOutput("add12_high", high_bcd, 16'h0012);
        checkOutput("add12_pulses", pulses, 12);
        checkOutput("add12_gameover", gameover, 1'b0);
        tick();
        checkOutput("add12_pulse_end", new_high, 1'b0);

        $display("[TB] carry ripple and add/decr collision");
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        addMany(110, 4'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
        checkOutput("pre995", score_bcd, 16'h0995);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd7);
        checkOutput("add7_ripple", score_bcd, 16'h1002);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3);
        checkOutput("both_decr_wins", score_bcd, 16'h0999);
        tick();
        checkOutput("high_keeps_max", high_bcd, 16'h1002);

        $display("[TB] underflow and gameover");
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd4);
        checkOutput("pre_under", score_bcd, 16'h0004);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd9);
        checkOutput("under_score", score_bcd, 16'h0000);
        checkOutput("under_gameover", gameover, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
        checkOutput("go_add_ignored", score_bcd, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        checkOutput("clear_gameover", gameover, 1'b0);
        checkOutput("clear_keeps_high", high_bcd, 16'h1002);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd7);
        checkOutput("equal_decr_score", score_bcd, 16'h0000);
        checkOutput("equal_decr_go", gameover, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);

        $display("[TB] saturation at all nines");
        addMany(1110, 4'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd8);
        checkOutput("pre_sat", score_bcd, 16'h9998);
        checkOutput("pre_sat_flag", saturated, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
        checkOutput("sat_score", score_bcd, 16'h9999);
        checkOutput("sat_flag", saturated, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        checkOutput("sat_cleared", saturated, 1'b0);
        checkOutput("sat_clear_score", score_bcd, 16'h0000);
        checkOutput("sat_high", high_bcd, 16'h9999);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("amt0_as_1", score_bcd, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hF);
        checkOutput("amtF_as_1", score_bcd, 16'h0002);

        $display("[TB] rendering score 42");
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        addMany(4, 4'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd6);
        checkOutput("render_score", score_bcd, 16'h0042);
        probe(12'd699, 12'd10, 16'd19820, 1'b1, "slot2");
        probe(12'd579, 12'd10, 16'd620,   1'b0, "slot0_blank");
        probe(12'd619, 12'd10, 16'd600,   1'b0, "slot1_blank");
        probe(12'd739, 12'd10, 16'd10200, 1'b1, "slot3");
        probe(12'd798, 12'd10, 16'd10259, 1'b1, "right_edge");
        probe(12'd559, 12'd10, 16'd600,   1'b0, "left_edge");
        probe(12'd558, 12'd10, 16'd0,     1'b0, "left_out");
        probe(12'd699, 12'd79, 16'd23960, 1'b1, "bottom_row");
        probe(12'd699, 12'd80, 16'd0,     1'b0, "below_row");
        probe(12'd799, 12'd599, 16'd0,    1'b0, "wrap_frame");
        probe(12'd799, 12'd10, 16'd0,     1'b0, "wrap_line");

        $display("[TB] reset in the middle of a line");
        x_p = 12'd739;
        y_p = 12'd10;
        tick();
        rom_dout = 1'b1;
        #1;
        checkOutput("pre_reset_fill", isFilled, 1'b1);
        reset = 1'b1;
        tick();
        checkOutput("reset_fill", isFilled, 1'b0);
        checkOutput("reset_score", score_bcd, 16'h0000);
        checkOutput("reset_high", high_bcd, 16'h0000);
        reset = 1'b0;
        rom_dout = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
